// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending constants: unit width, state encoding, dispenser defaults
package vend_pkg;

    localparam int UNIT_W = 3;
    typedef logic [UNIT_W-1:0] unit_t;

    localparam int TMR_W = 8;

    localparam int BIG_VAL_DEF     = 5;
    localparam int SMALL_VAL       = 1;
    localparam int ACK_TIMEOUT_DEF = 15;
    localparam int GAP_CYCLES_DEF  = 2;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SELECT   = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_GAP      = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_FAULT    = 3'd5;

endpackage

// File: rtl/ack_timer.sv
// rtl/ack_timer.sv - loadable saturating down-counter shared by ack timeout and inter-coin gap
module ack_timer
    import vend_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Loaded with N-1 so expired is seen during the N-th counted cycle.
    assign expired = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy two-denomination change payout with ack timeout and sticky fault
module change_dispenser
    import vend_pkg::*;
#(
    parameter int BIG_VAL     = BIG_VAL_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [UNIT_W-1:0] VF,
    input  logic              vf_valid,
    output logic              vf_ready,
    output logic              hop_big_req,
    output logic              hop_small_req,
    input  logic              hop_ack,
    input  logic              fault_clr,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [UNIT_W-1:0] remaining
);

    localparam unit_t BIG_U   = unit_t'(BIG_VAL);
    localparam unit_t SMALL_U = unit_t'(SMALL_VAL);
    localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? TMR_W'(GAP_CYCLES - 1) : '0;

    logic [2:0]       state, state_nxt;
    logic             coin_big;
    unit_t            rem_dec;
    logic             tmr_load, tmr_en, tmr_expired;
    logic [TMR_W-1:0] tmr_val;

    ack_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    assign rem_dec = remaining - (coin_big ? BIG_U : SMALL_U);

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (vf_valid) begin
                    state_nxt = (VF == '0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                state_nxt = S_WAIT_ACK;
                tmr_load  = 1'b1;
                tmr_val   = ACK_LOAD;
            end
            S_WAIT_ACK: begin
                // An ack on the expiring edge still wins over the timeout.
                if (hop_ack) begin
                    if (rem_dec == '0) begin
                        state_nxt = S_DONE;
                    end else if (GAP_CYCLES == 0) begin
                        state_nxt = S_SELECT;
                    end else begin
                        state_nxt = S_GAP;
                        tmr_load  = 1'b1;
                        tmr_val   = GAP_LOAD;
                    end
                end else if (tmr_expired) begin
                    state_nxt = S_FAULT;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_expired) begin
                    state_nxt = S_SELECT;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            S_FAULT: begin
                if (fault_clr) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            coin_big  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE:     if (vf_valid) remaining <= VF;
                S_SELECT:   coin_big <= (remaining >= BIG_U);
                S_WAIT_ACK: if (hop_ack) remaining <= rem_dec;
                S_FAULT:    if (fault_clr) remaining <= '0;
                default:    ;
            endcase
        end
    end

    assign vf_ready      = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign fault         = (state == S_FAULT);
    assign hop_big_req   = (state == S_WAIT_ACK) &&  coin_big;
    assign hop_small_req = (state == S_WAIT_ACK) && !coin_big;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - table-driven and scoreboard bench for change_dispenser
module tb_change_dispenser;

    localparam int BIG = 5;

    logic       clock;
    logic       reset;
    logic [2:0] VF;
    logic       vf_valid;
    logic       vf_ready;
    logic       hop_big_req;
    logic       hop_small_req;
    logic       hop_ack;
    logic       fault_clr;
    logic       busy;
    logic       done;
    logic       fault;
    logic [2:0] remaining;

    change_dispenser dut (
        .clock         (clock),
        .reset         (reset),
        .VF            (VF),
        .vf_valid      (vf_valid),
        .vf_ready      (vf_ready),
        .hop_big_req   (hop_big_req),
        .hop_small_req (hop_small_req),
        .hop_ack       (hop_ack),
        .fault_clr     (fault_clr),
        .busy          (busy),
        .done          (done),
        .fault         (fault),
        .remaining     (remaining)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       big;
        logic [2:0] rem;
    } coin_t;
    coin_t exp_q[$];

    typedef struct {
        logic [2:0] vf;
        int         lat;
        logic       disturb;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic pay(input logic [2:0] v, input int lat, input logic dis);
        coin_t c;
        coin_t e;
        int r;
        r = v;
        while (r > 0) begin
            c.big = (r >= BIG);
            r = r - (c.big ? BIG : 1);
            c.rem = 3'(r);
            exp_q.push_back(c);
        end
        VF = v;
        vf_valid = 1'b1;
        tick;
        vf_valid = 1'b0;
        chk("xfer_busy", busy, 1);
        chk("xfer_rem", remaining, v);
        chk("xfer_ready", vf_ready, 0);
        chk("xfer_req", hop_big_req | hop_small_req, 0);
        if (v == 0) begin
            chk("zero_done", done, 1);
            tick;
            chk("zero_ready", vf_ready, 1);
            chk("zero_done_end", done, 0);
            chk("zero_req", hop_big_req | hop_small_req, 0);
        end else begin
            tick;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("coin_big", hop_big_req, e.big);
                chk("coin_small", hop_small_req, !e.big);
                repeat (lat) begin
                    tick;
                    chk("coin_held", {hop_big_req, hop_small_req}, {e.big, !e.big});
                end
                hop_ack = 1'b1;
                tick;
                hop_ack = 1'b0;
                chk("ack_req_low", hop_big_req | hop_small_req, 0);
                chk("ack_rem", remaining, e.rem);
                chk("ack_fault", fault, 0);
                if (e.rem == 0) begin
                    chk("final_done", done, 1);
                end else begin
                    chk("mid_done", done, 0);
                    tick;
                    chk("gap_req_a", hop_big_req | hop_small_req, 0);
                    if (dis) begin
                        VF = 3'd5;
                        vf_valid = 1'b1;
                        hop_ack = 1'b1;
                    end
                    tick;
                    vf_valid = 1'b0;
                    hop_ack = 1'b0;
                    chk("gap_req_b", hop_big_req | hop_small_req, 0);
                    chk("gap_rem", remaining, e.rem);
                    tick;
                end
            end
            tick;
            chk("end_ready", vf_ready, 1);
            chk("end_busy", busy, 0);
            chk("end_done", done, 0);
            chk("end_rem", remaining, 0);
        end
    endtask

    initial begin
        int held;
        reset = 1'b0;
        VF = 3'd0;
        vf_valid = 1'b0;
        hop_ack = 1'b0;
        fault_clr = 1'b0;

        vecs[0] = '{vf: 3'd7, lat: 1,  disturb: 1'b0};
        vecs[1] = '{vf: 3'd0, lat: 1,  disturb: 1'b0};
        vecs[2] = '{vf: 3'd3, lat: 1,  disturb: 1'b0};
        vecs[3] = '{vf: 3'd5, lat: 0,  disturb: 1'b0};
        vecs[4] = '{vf: 3'd6, lat: 2,  disturb: 1'b0};
        vecs[5] = '{vf: 3'd4, lat: 3,  disturb: 1'b0};
        vecs[6] = '{vf: 3'd7, lat: 1,  disturb: 1'b1};
        vecs[7] = '{vf: 3'd1, lat: 14, disturb: 1'b0};
        vecs[8] = '{vf: 3'd2, lat: 0,  disturb: 1'b1};

        tick;
        tick;
        chk("rst_ready", vf_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_req", hop_big_req | hop_small_req, 0);
        reset = 1'b1;
        tick;

        for (int i = 0; i < 9; i++) begin
            pay(vecs[i].vf, vecs[i].lat, vecs[i].disturb);
            tick;
        end

        VF = 3'd6;
        vf_valid = 1'b1;
        tick;
        vf_valid = 1'b0;
        tick;
        held = 0;
        for (int i = 0; i < 40 && !fault; i++) begin
            if (hop_big_req) held++;
            tick;
        end
        chk("to_held", held, 15);
        chk("to_fault", fault, 1);
        chk("to_rem", remaining, 6);
        chk("to_req", hop_big_req | hop_small_req, 0);
        chk("to_busy", busy, 1);
        hop_ack = 1'b1;
        vf_valid = 1'b1;
        VF = 3'd2;
        tick;
        hop_ack = 1'b0;
        vf_valid = 1'b0;
        chk("fault_sticky", fault, 1);
        chk("fault_rem_frozen", remaining, 6);
        fault_clr = 1'b1;
        tick;
        fault_clr = 1'b0;
        chk("clr_fault", fault, 0);
        chk("clr_rem", remaining, 0);
        chk("clr_ready", vf_ready, 1);
        chk("clr_busy", busy, 0);
        tick;

        VF = 3'd3;
        vf_valid = 1'b1;
        tick;
        vf_valid = 1'b0;
        tick;
        chk("pre_rst_req", hop_small_req, 1);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        chk("mid_rst_req", hop_big_req | hop_small_req, 0);
        chk("mid_rst_rem", remaining, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", vf_ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_fault", fault, 0);
        pay(3'd1, 1, 1'b0);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
